// File: rtl/icache_responder_pkg.sv
// Shared configuration for the instruction cache: default widths, constants
// and FSM state encodings.
package icache_responder_pkg;

  localparam int ICACHE_ADDR_W  = 32;
  localparam int ICACHE_INSTR_W = 32;
  localparam int ICACHE_INDEX_W = 8;

  localparam logic ZERO  = 1'b0;
  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    ICacheIdle   = 2'd0,
    ICacheMiss   = 2'd1,
    ICacheReplay = 2'd2
  } icache_state_e;

endpackage

// File: rtl/icache_tag_data_array.sv
// Direct-mapped valid/tag/data store: combinational read, one synchronous
// write port, valid bits cleared by the async reset.
module icache_tag_data_array #(
  parameter int INDEX_WIDTH = 8,
  parameter int TAG_WIDTH   = 22,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [INDEX_WIDTH-1:0] rd_idx_i,
  output logic                   rd_vld_o,
  output logic [TAG_WIDTH-1:0]   rd_tag_o,
  output logic [DATA_WIDTH-1:0]  rd_data_o,
  input  logic                   wr_en_i,
  input  logic [INDEX_WIDTH-1:0] wr_idx_i,
  input  logic [TAG_WIDTH-1:0]   wr_tag_i,
  input  logic [DATA_WIDTH-1:0]  wr_data_i
);

  localparam int LINES = 1 << INDEX_WIDTH;

  logic [LINES-1:0]      vld_q;
  logic [TAG_WIDTH-1:0]  tag_q  [LINES];
  logic [DATA_WIDTH-1:0] data_q [LINES];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)    vld_q           <= '0;
    else if (wr_en_i) vld_q[wr_idx_i] <= 1'b1;
  end

  // Tag/data need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk_in) begin
    if (wr_en_i) begin
      tag_q[wr_idx_i]  <= wr_tag_i;
      data_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_vld_o  = vld_q[rd_idx_i];
  assign rd_tag_o  = tag_q[rd_idx_i];
  assign rd_data_o = data_q[rd_idx_i];

endmodule

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache answering fetch requests, with miss fill
// from memory and branch-flush handling that never abandons a memory read.
module icache_responder
  import icache_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = ICACHE_ADDR_W,
  parameter int INSTR_WIDTH = ICACHE_INSTR_W,
  parameter int INDEX_WIDTH = ICACHE_INDEX_W
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   rdy_in,
  input  logic                   if_to_icache_en_in,
  input  logic [ADDR_WIDTH-1:0]  if_a_in,
  output logic                   icache_to_if_en_out,
  output logic [INSTR_WIDTH-1:0] if_d_out,
  output logic                   icache_to_mem_en_out,
  output logic [ADDR_WIDTH-1:0]  icache_a_out,
  input  logic                   mem_to_icache_en_in,
  input  logic [INSTR_WIDTH-1:0] mem_d_in,
  input  logic                   clear_branch_in
);

  localparam int TAG_W = ADDR_WIDTH - INDEX_WIDTH - 2;

  icache_state_e           state_q, state_d;
  logic [ADDR_WIDTH-1:2]   miss_word_q, miss_word_d;
  logic [ADDR_WIDTH-1:2]   pend_word_q, pend_word_d;
  logic                    pend_q, pend_d;
  logic                    drop_q, drop_d;
  logic                    resp_en_q, resp_en_d;
  logic [INSTR_WIDTH-1:0]  resp_d_q, resp_d_d;
  logic                    mem_en_q, mem_en_d;
  logic [ADDR_WIDTH-1:0]   mem_a_q, mem_a_d;

  logic [ADDR_WIDTH-1:2]   lk_word;
  logic                    rd_vld, hit, lookup, fill_en;
  logic [TAG_W-1:0]        rd_tag;
  logic [INSTR_WIDTH-1:0]  rd_data;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^if_a_in[1:0];

  // REPLAY looks up the parked address; otherwise the live fetch address.
  assign lk_word = (state_q == ICacheReplay) ? pend_word_q : if_a_in[ADDR_WIDTH-1:2];
  assign hit     = rd_vld && (rd_tag == lk_word[ADDR_WIDTH-1:INDEX_WIDTH+2]);
  assign lookup  = !clear_branch_in &&
                   (((state_q == ICacheIdle) && if_to_icache_en_in) ||
                    (state_q == ICacheReplay));
  assign fill_en = rdy_in && (state_q == ICacheMiss) && mem_to_icache_en_in;

  icache_tag_data_array #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .TAG_WIDTH   (TAG_W),
    .DATA_WIDTH  (INSTR_WIDTH)
  ) u_array (
    .clk_in    (clk_in),
    .rst_n_in  (rst_n_in),
    .rd_idx_i  (lk_word[INDEX_WIDTH+1:2]),
    .rd_vld_o  (rd_vld),
    .rd_tag_o  (rd_tag),
    .rd_data_o (rd_data),
    .wr_en_i   (fill_en),
    .wr_idx_i  (miss_word_q[INDEX_WIDTH+1:2]),
    .wr_tag_i  (miss_word_q[ADDR_WIDTH-1:INDEX_WIDTH+2]),
    .wr_data_i (mem_d_in)
  );

  always_comb begin
    state_d     = state_q;
    miss_word_d = miss_word_q;
    pend_word_d = pend_word_q;
    pend_d      = pend_q;
    drop_d      = drop_q;
    resp_en_d   = FALSE;
    resp_d_d    = resp_d_q;
    mem_en_d    = FALSE;
    mem_a_d     = mem_a_q;

    unique case (state_q)
      ICacheIdle, ICacheReplay: begin
        // Leaving REPLAY always consumes the parked request, flushed or not.
        if (state_q == ICacheReplay) begin
          pend_d  = FALSE;
          state_d = ICacheIdle;
        end
        if (lookup) begin
          if (hit) begin
            resp_en_d = TRUE;
            resp_d_d  = rd_data;
          end else begin
            mem_en_d    = TRUE;
            mem_a_d     = {lk_word, 2'b00};
            miss_word_d = lk_word;
            state_d     = ICacheMiss;
          end
        end
      end

      ICacheMiss: begin
        // A flush kills the response and any parked request, but the read
        // already issued to memory still has to be absorbed.
        if (clear_branch_in) begin
          drop_d = TRUE;
          pend_d = FALSE;
        end else if (if_to_icache_en_in && drop_q) begin
          pend_d      = TRUE;
          pend_word_d = if_a_in[ADDR_WIDTH-1:2];
        end
        if (mem_to_icache_en_in) begin
          if (!drop_q && !clear_branch_in) begin
            resp_en_d = TRUE;
            resp_d_d  = mem_d_in;
          end
          drop_d  = FALSE;
          state_d = pend_d ? ICacheReplay : ICacheIdle;
        end
      end

      default: state_d = ICacheIdle;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ICacheIdle;
      miss_word_q <= '0;
      pend_word_q <= '0;
      pend_q      <= ZERO;
      drop_q      <= ZERO;
      resp_en_q   <= ZERO;
      resp_d_q    <= '0;
      mem_en_q    <= ZERO;
      mem_a_q     <= '0;
    end else if (rdy_in) begin
      state_q     <= state_d;
      miss_word_q <= miss_word_d;
      pend_word_q <= pend_word_d;
      pend_q      <= pend_d;
      drop_q      <= drop_d;
      resp_en_q   <= resp_en_d;
      resp_d_q    <= resp_d_d;
      mem_en_q    <= mem_en_d;
      mem_a_q     <= mem_a_d;
    end
  end

  assign icache_to_if_en_out  = resp_en_q;
  assign if_d_out             = resp_d_q;
  assign icache_to_mem_en_out = mem_en_q;
  assign icache_a_out         = mem_a_q;

endmodule
